// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control path:
// opcodes, T-steps, A-source select and the per-cycle control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_STA = 4'h6,
    OP_LDI = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_JC  = 4'hA,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5
  } step_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef enum logic [1:0] {
    SRC_RAM = 2'd0,
    SRC_ALU = 2'd1,
    SRC_IMM = 2'd2
  } a_src_t;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       mar_src;
    logic       ir_load;
    logic       ram_rd;
    logic       ram_wr;
    logic       a_load;
    a_src_t     a_src;
    logic       b_load;
    logic       alu_en;
    logic [1:0] alu_op;
    logic       out_load;
  } ctrl_t;

  // ADD..AND are consecutive opcodes starting at 2
  function automatic logic [1:0] alu_op_of(input opcode_t op);
    logic [3:0] d;
    d = op - 4'd2;
    return d[1:0];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microstep decoder: (step, opcode, flags, mem_ready)
// to control word, next step and halt request.
import cpu_pkg::*;

module ctrl_decode (
  input  step_t   i_step,
  input  opcode_t i_opc,
  input  logic    i_f_z,
  input  logic    i_f_c,
  input  logic    i_mem_ready,
  output ctrl_t   o_cw,
  output step_t   o_nxt,
  output logic    o_hlt
);

  logic w_is_alu;

  assign w_is_alu = (i_opc == OP_ADD) || (i_opc == OP_SUB) ||
                    (i_opc == OP_OR)  || (i_opc == OP_AND);

  always_comb begin
    o_cw  = '0;
    o_nxt = i_step;
    o_hlt = 1'b0;
    unique case (i_step)
      T0: begin
        o_cw.mar_load = 1'b1;
        o_nxt         = T1;
      end
      T1: begin
        o_cw.ram_rd = 1'b1;
        if (i_mem_ready) begin
          o_cw.ir_load = 1'b1;
          o_cw.pc_inc  = 1'b1;
          o_nxt        = T2;
        end
      end
      T2: begin
        o_nxt = T0;
        case (i_opc)
          OP_LDA, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_STA: begin
            o_cw.mar_load = 1'b1;
            o_cw.mar_src  = 1'b1;
            o_nxt         = T3;
          end
          OP_LDI: begin
            o_cw.a_load = 1'b1;
            o_cw.a_src  = SRC_IMM;
          end
          OP_JMP: o_cw.pc_load  = 1'b1;
          OP_JZ:  o_cw.pc_load  = i_f_z;
          OP_JC:  o_cw.pc_load  = i_f_c;
          OP_OUT: o_cw.out_load = 1'b1;
          OP_HLT: o_hlt         = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        if (i_opc == OP_STA) begin
          o_cw.ram_wr = 1'b1;
          if (i_mem_ready) o_nxt = T0;
        end else if (i_opc == OP_LDA) begin
          o_cw.ram_rd = 1'b1;
          if (i_mem_ready) begin
            o_cw.a_load = 1'b1;
            o_cw.a_src  = SRC_RAM;
            o_nxt       = T0;
          end
        end else if (w_is_alu) begin
          o_cw.ram_rd = 1'b1;
          if (i_mem_ready) begin
            o_cw.b_load = 1'b1;
            o_nxt       = T4;
          end
        end else begin
          o_nxt = T0;
        end
      end
      T4: begin
        o_nxt = T0;
        if (w_is_alu) begin
          o_cw.alu_en = 1'b1;
          o_cw.alu_op = alu_op_of(i_opc);
          o_nxt       = T5;
        end
      end
      T5: begin
        // registered ALU result is valid one cycle after alu_en
        o_cw.a_load = 1'b1;
        o_cw.a_src  = SRC_ALU;
        o_nxt       = T0;
      end
      default: o_nxt = T0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction-cycle sequencer: step/halt registers plus strobe gating
// around the combinational microstep decoder.
import cpu_pkg::*;

module cpu_ctrl #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       f_z,
  input  logic       f_c,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       mar_src,
  output logic       ir_load,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic       a_load,
  output logic [1:0] a_src,
  output logic       b_load,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic       out_load,
  output logic       halt
);

  step_t r_step;
  logic  r_halted;
  ctrl_t w_cw;
  ctrl_t w_cw_g;
  step_t w_nxt;
  logic  w_hlt;
  logic  w_go;
  logic  w_unused;

  // operand bits are routed by the datapath, not the sequencer
  assign w_unused = ^instr[ADDR_W-1:0];

  ctrl_decode u_dec (
    .i_step      (r_step),
    .i_opc       (opcode_t'(instr[7 -: OPC_W])),
    .i_f_z       (f_z),
    .i_f_c       (f_c),
    .i_mem_ready (mem_ready),
    .o_cw        (w_cw),
    .o_nxt       (w_nxt),
    .o_hlt       (w_hlt)
  );

  assign w_go   = en & ~rst & ~r_halted;
  assign w_cw_g = w_go ? w_cw : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else if (w_go) begin
      r_step <= w_nxt;
      if (w_hlt) r_halted <= 1'b1;
    end
  end

  assign pc_inc   = w_cw_g.pc_inc;
  assign pc_load  = w_cw_g.pc_load;
  assign mar_load = w_cw_g.mar_load;
  assign mar_src  = w_cw_g.mar_src;
  assign ir_load  = w_cw_g.ir_load;
  assign ram_rd   = w_cw_g.ram_rd;
  assign ram_wr   = w_cw_g.ram_wr;
  assign a_load   = w_cw_g.a_load;
  assign a_src    = w_cw_g.a_src;
  assign b_load   = w_cw_g.b_load;
  assign alu_en   = w_cw_g.alu_en;
  assign alu_op   = w_cw_g.alu_op;
  assign out_load = w_cw_g.out_load;
  assign halt     = r_halted;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed scenarios plus randomized traffic,
// checked against a microprogram-queue reference model.
module tb_cpu_ctrl;

  localparam logic [15:0] PCI  = 16'h8000;
  localparam logic [15:0] PCL  = 16'h4000;
  localparam logic [15:0] MARL = 16'h2000;
  localparam logic [15:0] MARS = 16'h1000;
  localparam logic [15:0] IRL  = 16'h0800;
  localparam logic [15:0] RD   = 16'h0400;
  localparam logic [15:0] WR   = 16'h0200;
  localparam logic [15:0] AL   = 16'h0100;
  localparam logic [15:0] ASAL = 16'h0040;
  localparam logic [15:0] ASIM = 16'h0080;
  localparam logic [15:0] BL   = 16'h0020;
  localparam logic [15:0] AEN  = 16'h0010;
  localparam logic [15:0] OUTL = 16'h0002;
  localparam logic [15:0] HLTB = 16'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] instr;
  logic       mem_ready;
  logic       f_z;
  logic       f_c;
  logic       pc_inc, pc_load, mar_load, mar_src, ir_load;
  logic       ram_rd, ram_wr, a_load, b_load, alu_en;
  logic       out_load, halt;
  logic [1:0] a_src, alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_w;

  typedef struct {
    logic [15:0] req;
    logic [15:0] done;
    bit          mem;
    bit          fetch_end;
    int          kind;
  } item_t;

  item_t q[$];
  bit    m_halted;

  cpu_ctrl #(.ADDR_W(4), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr),
    .mem_ready(mem_ready), .f_z(f_z), .f_c(f_c),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .mar_src(mar_src), .ir_load(ir_load), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .a_load(a_load), .a_src(a_src),
    .b_load(b_load), .alu_en(alu_en), .alu_op(alu_op),
    .out_load(out_load), .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dut_word();
    return {pc_inc, pc_load, mar_load, mar_src, ir_load, ram_rd,
            ram_wr, a_load, a_src, b_load, alu_en, alu_op,
            out_load, halt};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input logic [15:0] req,
                               input logic [15:0] done,
                               input bit mem, input bit fe,
                               input int kind);
    item_t it;
    it.req = req; it.done = done; it.mem = mem;
    it.fetch_end = fe; it.kind = kind;
    return it;
  endfunction

  task automatic push_exec(input int opc);
    logic [15:0] op;
    op = 16'(opc - 2) << 2;
    case (opc)
      1: begin
        q.push_back(mk(MARL | MARS, 0, 0, 0, 0));
        q.push_back(mk(RD, AL, 1, 0, 0));
      end
      2, 3, 4, 5: begin
        q.push_back(mk(MARL | MARS, 0, 0, 0, 0));
        q.push_back(mk(RD, BL, 1, 0, 0));
        q.push_back(mk(AEN | op, 0, 0, 0, 0));
        q.push_back(mk(AL | ASAL, 0, 0, 0, 0));
      end
      6: begin
        q.push_back(mk(MARL | MARS, 0, 0, 0, 0));
        q.push_back(mk(WR, 0, 1, 0, 0));
      end
      7:  q.push_back(mk(AL | ASIM, 0, 0, 0, 0));
      8:  q.push_back(mk(PCL, 0, 0, 0, 0));
      9:  q.push_back(mk(0, 0, 0, 0, 1));
      10: q.push_back(mk(0, 0, 0, 0, 2));
      14: q.push_back(mk(OUTL, 0, 0, 0, 0));
      15: q.push_back(mk(0, 0, 0, 0, 3));
      default: q.push_back(mk(0, 0, 0, 0, 0));
    endcase
  endtask

  // Expected outputs for this cycle, then advance model to next cycle
  task automatic model(input bit e, input bit mr, input bit fz,
                       input bit fc, output logic [15:0] exp);
    item_t it;
    exp = '0;
    if (m_halted) begin
      exp = HLTB;
    end else if (e) begin
      if (q.size() == 0) begin
        q.push_back(mk(MARL, 0, 0, 0, 0));
        q.push_back(mk(RD, IRL | PCI, 1, 1, 0));
      end
      it = q[0];
      if (it.mem && !mr) begin
        exp = it.req;
      end else begin
        exp = it.req | it.done;
        if (it.kind == 1 && fz) exp |= PCL;
        if (it.kind == 2 && fc) exp |= PCL;
        void'(q.pop_front());
        if (it.fetch_end) push_exec(int'(instr[7:4]));
        if (it.kind == 3) m_halted = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit e, input bit mr, input bit fz,
                     input bit fc, input string tag);
    logic [15:0] x;
    en = e; mem_ready = mr; f_z = fz; f_c = fc;
    @(negedge clk);
    model(e, mr, fz, fc, x);
    last_w = dut_word();
    chk(tag, last_w, x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_zero", dut_word(), 16'h0000);
    #2;
    rst = 1'b0;
    q.delete();
    m_halted = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int rd_n, bl_n, wr_done;
  int hold;

  initial begin
    rst = 1'b1; en = 1'b0; instr = 8'h00;
    mem_ready = 1'b0; f_z = 1'b0; f_c = 1'b0;
    m_halted = 1'b0;
    #3;
    chk("reset_state", dut_word(), 16'h0000);
    @(posedge clk);
    #1;
    do_reset();

    // ADD 5, no stalls
    instr = 8'h25;
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, "add_seq");
    cyc(1, 1, 0, 0, "add_back_t0");
    chk("add_t0_word", last_w, MARL);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, "add_seq2");

    // SUB with 3 stall cycles in T3
    instr = 8'h39;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "sub_fetch");
    rd_n = 0; bl_n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 3), 0, 0, "sub_t3");
      rd_n += int'(last_w[10]);
      bl_n += int'(last_w[5]);
    end
    chk("sub_rd_cnt", 16'(rd_n), 16'd4);
    chk("sub_bl_cnt", 16'(bl_n), 16'd1);
    cyc(1, 1, 0, 0, "sub_t4");
    chk("sub_alu", last_w, AEN | 16'h0004);
    cyc(1, 1, 0, 0, "sub_t5");

    // JZ taken / not taken
    instr = 8'h97;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, "jz1");
    chk("jz1_pcl", last_w, PCL);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, "jz0");
    chk("jz0_pcl", last_w, 16'h0000);
    cyc(1, 1, 0, 0, "jz_back_t0");

    // AND with async reset in T4
    do_reset();
    instr = 8'h51;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, "and_pre");
    chk("and_t4_aluen", {15'b0, alu_en}, 16'h0001);
    do_reset();
    cyc(1, 1, 0, 0, "and_after_rst");
    chk("and_rst_t0", last_w, MARL);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, "and_full");

    // STA with en dropped mid-handshake
    instr = 8'h64;
    wr_done = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "sta_pre");
    cyc(1, 0, 0, 0, "sta_wait");
    chk("sta_wr_hi", last_w, WR);
    for (int i = 0; i < 3; i++) begin
      cyc(0, (i == 1), 0, 0, "sta_en0");
      chk("sta_wr_lo", last_w, 16'h0000);
    end
    cyc(1, 0, 0, 0, "sta_resume");
    chk("sta_wr_again", last_w, WR);
    cyc(1, 1, 0, 0, "sta_done");
    if (last_w[9]) wr_done++;
    chk("sta_single_wr", 16'(wr_done), 16'd1);
    cyc(1, 1, 0, 0, "sta_next_t0");

    // HLT
    do_reset();
    instr = 8'hF0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "hlt_pre");
    for (int i = 0; i < 20; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          1, 1, "hlt_stuck");
      chk("hlt_word", last_w, HLTB);
    end
    do_reset();

    // randomized traffic
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0 && !m_halted) begin
        instr = 8'($urandom);
        if (instr[7:4] == 4'hF && $urandom_range(0, 3) != 0)
          instr[7:4] = 4'h2;
      end
      if (m_halted) hold++;
      if (hold > 4 || $urandom_range(0, 299) == 0) begin
        hold = 0;
        do_reset();
      end
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Instruction-cycle sequencer for the 8-bit CPU.
- Steps a T-state counter through fetch/execute microsteps and decodes the instruction register into one control word per cycle.
- The control word drives PC, MAR, IR, RAM, A/B registers, output register, and the registered ALU (alu_en, alu_op).
- Consumes the ALU's registered f_z/f_c for conditional jumps.
- Stalls on a memory-ready handshake.

Parameters:
- ADDR_W, 4, width of operand/address field (instr[ADDR_W-1:0]).
- OPC_W, 4, width of opcode field (instr[7:4]).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; 0 freezes step state, all strobes forced 0
- instr  in  8  current IR contents; opcode = instr[7:4]
- mem_ready  in  1  RAM access complete this cycle (read data valid / write accepted)
- f_z  in  1  ALU zero flag (registered in ALU)
- f_c  in  1  ALU carry flag (registered in ALU)
- pc_inc  out  1  increment PC
- pc_load  out  1  load PC from instr[3:0]
- mar_load  out  1  load MAR
- mar_src  out  1  MAR source: 0 = PC, 1 = instr[3:0]
- ir_load  out  1  load IR from RAM data
- ram_rd  out  1  RAM read request
- ram_wr  out  1  RAM write request (data = A)
- a_load  out  1  load A register
- a_src  out  2  A source: 0 = RAM, 1 = ALU out, 2 = zero-extended instr[3:0]
- b_load  out  1  load B from RAM data
- alu_en  out  1  ALU enable
- alu_op  out  2  ALU op: 00 ADD, 01 SUB, 10 OR, 11 AND
- out_load  out  1  load output register from A
- halt  out  1  CPU halted (sticky)

Behaviour:
- State
  - step register T0..T5, plus halted flag.
  - Control word is a combinational function of (step, opcode, f_z, f_c, halted).
  - While rst=1, or en=0, or halted=1, all strobes are 0; a_src, mar_src and alu_op read 0.
- Reset (asynchronous): step=T0, halted=0, halt=0.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OR, 5 AND, 6 STA, 7 LDI, 8 JMP, 9 JZ, A JC, E OUT, F HLT. B, C, D decode as NOP.
- Fetch (all opcodes)
  - T0: mar_load, mar_src=0.
  - T1: ram_rd, ir_load, pc_inc.
  - instr is valid from T2 onward.
- Execute, from T2 (->T0 means next step is T0)
  - LDA: T2 mar_load, mar_src=1. T3 ram_rd, a_load, a_src=0 ->T0.
  - ADD/SUB/OR/AND:
    - T2 mar_load, mar_src=1.
    - T3 ram_rd, b_load.
    - T4 alu_en with alu_op = opcode-2.
    - T5 a_load, a_src=1 ->T0.
    - The ALU result is registered, so it is valid in T5: exactly one cycle after alu_en.
  - STA: T2 mar_load, mar_src=1. T3 ram_wr ->T0.
  - LDI: T2 a_load, a_src=2 ->T0.
  - JMP: T2 pc_load ->T0.
  - JZ: T2 pc_load = f_z ->T0. JC: T2 pc_load = f_c ->T0. Flags are sampled combinationally in T2.
  - OUT: T2 out_load ->T0.
  - NOP/undefined: T2 no strobes ->T0.
  - HLT: at T2, halted<=1 and step<=T0. halt=1 from the next cycle until rst.
- Memory handshake
  - In T1 and in LDA/ALU-op/STA T3, step advances only when mem_ready=1.
  - While waiting, the request strobe (ram_rd/ram_wr) stays high.
  - Load/increment strobes (ir_load, pc_inc, a_load, b_load) are asserted only in the cycle where mem_ready=1, so each fires exactly once per access.
- en=0
  - Step holds with all strobes 0.
  - Resuming re-presents the same step's control word.
  - en=0 mid-handshake drops ram_rd/ram_wr until en returns.
- Reset mid-instruction: immediate return to T0, strobes 0, no partial writeback.
- alu_en is asserted for exactly one cycle per ALU instruction. No other opcode asserts it, so ALU flags persist across non-ALU instructions.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode enum;
  - step enum (T0..T5);
  - ALU op constants ADD/SUB/OR/AND (00/01/10/11);
  - a_src enum (SRC_RAM, SRC_ALU, SRC_IMM);
  - control-word struct.
- One sub-module, ctrl_decode: purely combinational (step, opcode, flags, mem_ready) -> control word + next step.
- cpu_ctrl holds the step/halted registers and the gating.

Test Plan:
- Reset, then en=1, mem_ready=1, instr=8'h25 (ADD 5):
  - T0..T5 = mar_load(src0); ram_rd+ir_load+pc_inc; mar_load(src1); ram_rd+b_load; alu_en, alu_op=00; a_load, a_src=1.
  - Back to T0 at cycle 6.
- instr=8'h39 (SUB) with mem_ready low 3 cycles in T3:
  - ram_rd high 4 cycles, b_load only in the 4th;
  - alu_en follows next cycle with alu_op=01.
- instr=8'h97 (JZ 7): f_z=1 -> pc_load=1 at T2. f_z=0 -> pc_load=0. Both return to T0 after 3 cycles.
- instr=8'hF0 (HLT): halt=1 from cycle 3 and stays; every strobe stays 0 for 20 further cycles; rst clears halt.
- Assert rst asynchronously during T4 of instr=8'h51 (AND):
  - all strobes 0 immediately, including alu_en;
  - after release, T0 asserts mar_load, mar_src=0.
- en=0 during T3 of instr=8'h64 (STA 4): ram_wr drops for that period; re-asserts when en=1; a single ram_wr completes on mem_ready.
